// File: rtl/ha_acc_pkg.sv
// Shared types for the half-adder result accumulator: FSM state encoding and sample width.
package ha_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SAMPLE_W = 2;

endpackage

// File: rtl/ha_result_accumulator_sat_add.sv
// Saturating adder: ACC_W-bit running value plus a SAMPLE_W-bit sample, clamped to all-ones.
module sat_add
  import ha_acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]    a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [ACC_W-1:0]    sum,
  output logic                ovf
);

  logic [ACC_W:0] wide;

  // One extra bit of headroom exposes the carry-out used as the overflow flag.
  assign wide = {1'b0, a} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, b};
  assign ovf  = wide[ACC_W];
  assign sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/ha_result_accumulator.sv
// Frame accumulator for {carry,sum} half-adder results with a valid/ready result port.
module ha_result_accumulator
  import ha_acc_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] next_sum;
  logic             next_ovf;
  logic             accept;
  logic             last;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt == CNT_W'(N_SAMPLES - 1));

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   ({in_carry, in_sum}),
    .sum (next_sum),
    .ovf (next_ovf)
  );

  // Frame FSM with counter, accumulator and registered result port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= {ACC_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      out_acc   <= {ACC_W{1'b0}};
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            acc     <= {ACC_W{1'b0}};
            cnt     <= {CNT_W{1'b0}};
            out_ovf <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= next_sum;
            cnt <= cnt + CNT_W'(1);
            if (next_ovf) begin
              out_ovf <= 1'b1;
            end
            // The last sample lands in out_acc directly so the result is visible one cycle later.
            if (last) begin
              out_acc   <= next_sum;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_result_accumulator.sv
// Scoreboard bench: two instances (ACC_W=8 and ACC_W=4) share stimulus; a model predicts each frame.
module tb_ha_result_accumulator;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_sum, in_carry, out_ready;
  logic       in_ready, busy, out_valid, out_ovf;
  logic [7:0] out_acc;
  logic       in_ready4, busy4, out_valid4, out_ovf4;
  logic [3:0] out_acc4;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int acc8;
    bit ovf8;
    int acc4;
    bit ovf4;
  } exp_t;
  exp_t sb[$];

  int m8, m4, mk;
  bit o8, o4;

  always #5 clk = ~clk;

  ha_result_accumulator #(.ACC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
    .in_carry(in_carry), .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  ha_result_accumulator #(.ACC_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
    .in_carry(in_carry), .in_ready(in_ready4), .busy(busy4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_acc(out_acc4), .out_ovf(out_ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m8 = 0; m4 = 0; o8 = 1'b0; o4 = 1'b0; mk = 0;
  endtask

  task automatic model_add(input int v);
    exp_t e;
    m8 += v;
    if (m8 > 255) begin m8 = 255; o8 = 1'b1; end
    m4 += v;
    if (m4 > 15) begin m4 = 15; o4 = 1'b1; end
    mk++;
    if (mk == 8) begin
      e.acc8 = m8; e.ovf8 = o8; e.acc4 = m4; e.ovf4 = o4;
      sb.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    check("armed_busy", busy, 1);
    check("armed_in_ready", in_ready, 1);
  endtask

  task automatic send(input bit c, input bit s, input int gap);
    for (int g = 0; g < gap; g++) step();
    in_valid = 1'b1; in_carry = c; in_sum = s;
    model_add({30'd0, c, s});
    step();
    in_valid = 1'b0; in_carry = 1'b0; in_sum = 1'b0;
  endtask

  task automatic collect();
    exp_t e;
    int w = 0;
    while (!out_valid && w < 10) begin
      step();
      w++;
    end
    check("latency", w, 0);
    check("out_valid", out_valid, 1);
    check("out_valid4", out_valid4, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("out_acc", out_acc, e.acc8);
      check("out_ovf", out_ovf, e.ovf8);
      check("out_acc4", out_acc4, e.acc4);
      check("out_ovf4", out_ovf4, e.ovf4);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_sum = 1'b0; in_carry = 1'b0; out_ready = 1'b0;
    model_clear();
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_acc", out_acc, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();

    // Basic frame of eight ones.
    do_start();
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 0);
    collect();
    handshake();
    step();
    check("idle_keeps_acc", out_acc, 8);

    // Alternating 2/0 with random gaps.
    do_start();
    for (int i = 0; i < 8; i++) send((i % 2) == 0, 1'b0, $urandom_range(0, 3));
    collect();
    handshake();

    // Saturation on the narrow instance, then cleared by the next start.
    do_start();
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 0);
    collect();
    handshake();
    do_start();
    check("ovf4_cleared", out_ovf4, 0);
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 0);
    collect();
    handshake();

    // DONE hold with out_ready low while in_valid/start toggle.
    do_start();
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 0);
    collect();
    held = out_acc;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_carry = 1'b1; in_sum = 1'b1; start = ~i[0];
      step();
      check("hold_acc", out_acc, held);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_busy", busy, 1);
    end
    in_valid = 1'b0; in_carry = 1'b0; in_sum = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    check("done_exit_valid", out_valid, 0);
    check("done_exit_busy", busy, 0);
    check("done_exit_in_ready", in_ready, 0);
    step();
    check("start_ignored_busy", busy, 0);

    // Reset in the middle of a frame.
    do_start();
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_acc", out_acc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("post_rst_busy", busy, 0);
    do_start();
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 0);
    collect();
    handshake();

    // start together with in_valid in IDLE: that sample is not counted.
    start = 1'b1; in_valid = 1'b1; in_carry = 1'b1; in_sum = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0; in_carry = 1'b0; in_sum = 1'b0;
    model_clear();
    check("armed_busy2", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check("no_early_valid", out_valid, 0);
      send(1'b0, 1'b1, 0);
    end
    collect();
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
